// File: rtl/adder_share_arbiter.sv
// Round-robin shared 8-bit adder: one registered result per accept, held until res_ready (busy while held).
// Optional ADD_SAT_EN macro clamps res_sum to 8'hFF on carry-out; res_carry always reports the raw carry.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int CNTW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_sum,
  output logic                 res_carry,
  output logic [IDW-1:0]       res_id,
  output logic                 busy,
  output logic [CNTW-1:0]      op_count,
  output logic [CNTW-1:0]      carry_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic           grant_found;
  logic           accept;
  logic           retire;
  logic [7:0]     op_a;
  logic [7:0]     op_b;
  logic [8:0]     sum_raw;
  logic [7:0]     sum_nxt;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NUM_REQ) ? s - NUM_REQ : s;
  endfunction

  // Walk offsets from highest to lowest so the requester closest to rr_ptr wins.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(int'(rr_ptr), k)]) begin
        grant       = IDW'(wrap_idx(int'(rr_ptr), k));
        grant_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // rst gates the grant so req_ready reads zero while reset is held.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    retire    = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_found && !rst) begin
          accept           = 1'b1;
          req_ready[grant] = 1'b1;
          state_nxt        = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign op_a    = req_a[int'(grant)*8 +: 8];
  assign op_b    = req_b[int'(grant)*8 +: 8];
  assign sum_raw = {1'b0, op_a} + {1'b0, op_b};

`ifdef ADD_SAT_EN
  assign sum_nxt = sum_raw[8] ? 8'hFF : sum_raw[7:0];
`else
  assign sum_nxt = sum_raw[7:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      res_sum     <= '0;
      res_carry   <= 1'b0;
      res_id      <= '0;
      op_count    <= '0;
      carry_count <= '0;
    end else begin
      if (accept) begin
        res_sum   <= sum_nxt;
        res_carry <= sum_raw[8];
        res_id    <= grant;
        rr_ptr    <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
      // Statistics count retirements, so a result dropped by reset is never counted.
      if (retire) begin
        if (op_count != '1) begin
          op_count <= op_count + 1'b1;
        end
        if (res_carry && (carry_count != '1)) begin
          carry_count <= carry_count + 1'b1;
        end
      end
    end
  end

  assign res_valid = (state == HOLD);
  assign busy      = (state == HOLD);

endmodule
